// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle for serial_add_ctrl.
// The master issues operands and start; the slave returns status and the result.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, through one full adder.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              reset_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_a, fa_b, fa_sum, fa_cout;

  assign fa_a = a_q[cnt_q];
  assign fa_b = b_q[cnt_q];

  one_bit_full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          // Subtract becomes add of the inverted operand with a forced carry-in.
          b_d     = bus.op_b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[cnt_q] = fa_sum;
        carry_d         = fa_cout;
        if (cnt_q == CntLast) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

  a_done_single: assert property (@(posedge clk) disable iff (!reset_n)
    bus.done |=> !bus.done);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(bus.busy && bus.done));
  a_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
    bus.busy |-> (cnt_q <= CntLast));
  a_idle_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == StIdle) |=> $stable(result_q) && $stable(cout_q) && $stable(ovf_q));

endmodule

module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 (directed + random) and WIDTH=2 (exhaustive).
module tb_serial_add_ctrl;

  localparam int unsigned W8 = 8;
  localparam int unsigned W2 = 2;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst8_n;
  logic rst2_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q2[$];
  int   free8 = 0;
  int   free2 = 0;
  int   blen8 = 0;
  logic [31:0] last8 = '0;

  serial_add_ctrl_if #(.WIDTH(W8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(W2)) bus2 ();

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk     (clk),
    .reset_n (rst8_n),
    .bus     (bus8)
  );

  serial_add_ctrl #(.WIDTH(W2)) dut2 (
    .clk     (clk),
    .reset_n (rst2_n),
    .bus     (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub, input int due);
    longint span = longint'(1) << w;
    longint ci   = cin ? 1 : 0;
    longint sa, sb, ures, sres;
    exp_t   e;
    sa = (a >= span / 2) ? a - span : a;
    sb = (b >= span / 2) ? b - span : b;
    if (sub) begin
      ures   = a - b;
      sres   = sa - sb;
      e.cout = (a >= b);
    end else begin
      ures   = a + b + ci;
      sres   = sa + sb + ci;
      e.cout = (ures >= span);
    end
    e.res = 32'(((ures % span) + span) % span);
    e.ovf = (sres < -(span / 2)) || (sres >= span / 2);
    e.due = due;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of start; the model decides whether the DUT is idle to accept it.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit c, input bit s);
    bus8.op_a  = a;
    bus8.op_b  = b;
    bus8.cin   = c;
    bus8.sub   = s;
    bus8.start = 1'b1;
    if (cyc + 1 >= free8) begin
      q8.push_back(model(W8, longint'(a), longint'(b), c, s, cyc + 1 + W8));
      free8 = cyc + 1 + W8 + 2;
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit c, input bit s);
    @(negedge clk);
    drive8(a, b, c, s);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.op_a  = 8'($urandom);
    bus8.op_b  = 8'($urandom);
    bus8.cin   = 1'($urandom);
    bus8.sub   = 1'($urandom);
  endtask

  task automatic wait8();
    int n = 0;
    while (q8.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w8_timeout: %0d ops pending, expected 0", q8.size());
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input bit c, input bit s);
    @(negedge clk);
    bus2.op_a  = a;
    bus2.op_b  = b;
    bus2.cin   = c;
    bus2.sub   = s;
    bus2.start = 1'b1;
    if (cyc + 1 >= free2) begin
      q2.push_back(model(W2, longint'(a), longint'(b), c, s, cyc + 1 + W2));
      free2 = cyc + 1 + W2 + 2;
    end
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.op_a  = 2'($urandom);
    bus2.op_b  = 2'($urandom);
    bus2.cin   = 1'($urandom);
    bus2.sub   = 1'($urandom);
  endtask

  task automatic wait2();
    int n = 0;
    while (q2.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL w2_timeout: %0d ops pending, expected 0", q2.size());
      q2.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (bus8.busy) begin
      blen8++;
    end else begin
      if (bus8.done) check("w8_busy_len", 32'(blen8), 32'(W8));
      blen8 = 0;
    end
    if (bus8.done) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_spurious_done: done=1 expected 0");
      end else begin
        e = q8.pop_front();
        check("w8_result", 32'(bus8.result), e.res);
        check("w8_cout", 32'(bus8.cout), 32'(e.cout));
        check("w8_overflow", 32'(bus8.overflow), 32'(e.ovf));
        check("w8_done_cycle", 32'(cyc), 32'(e.due));
        last8 = e.res;
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (bus2.done) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w2_spurious_done: done=1 expected 0");
      end else begin
        e = q2.pop_front();
        check("w2_result", 32'(bus2.result), e.res);
        check("w2_cout", 32'(bus2.cout), 32'(e.cout));
        check("w2_overflow", 32'(bus2.overflow), 32'(e.ovf));
        check("w2_done_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.op_a = '0; bus8.op_b = '0;
    bus2.start = 1'b0; bus2.sub = 1'b0; bus2.cin = 1'b0; bus2.op_a = '0; bus2.op_b = '0;
    rst8_n = 1'b0;
    rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_result", 32'(bus8.result), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    check("rst_overflow", 32'(bus8.overflow), 32'd0);
    rst8_n = 1'b1;
    rst2_n = 1'b1;

    issue8(8'h05, 8'h03, 1'b0, 1'b0); wait8();
    repeat (3) @(negedge clk);
    check("w8_idle_hold", 32'(bus8.result), last8);
    issue8(8'hFF, 8'h01, 1'b0, 1'b0); wait8();
    issue8(8'h7F, 8'h01, 1'b0, 1'b0); wait8();
    issue8(8'h10, 8'h01, 1'b1, 1'b1); wait8();
    issue8(8'h00, 8'h01, 1'b1, 1'b1); wait8();

    // Second start three cycles after acceptance must be dropped.
    issue8(8'h21, 8'h42, 1'b0, 1'b0);
    @(negedge clk);
    issue8(8'h99, 8'h11, 1'b1, 1'b1);
    wait8();

    // Reset four cycles into RUN abandons the operation.
    issue8(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_result", 32'(bus8.result), 32'd0);
    check("abort_cout", 32'(bus8.cout), 32'd0);
    check("abort_overflow", 32'(bus8.overflow), 32'd0);
    q8.delete();
    free8 = 0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1;
    issue8(8'h01, 8'h01, 1'b0, 1'b0); wait8();
    check("post_reset_result", 32'(bus8.result), 32'h02);

    // Start held high: one acceptance per idle window, operands changing every cycle.
    for (int k = 0; k < 3 * (W8 + 2) + 1; k++) begin
      @(negedge clk);
      drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    bus8.start = 1'b0;
    wait8();

    for (int k = 0; k < 40; k++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait8();
    end
    wait8();

    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        for (int a = 0; a < 4; a++) begin
          for (int b = 0; b < 4; b++) begin
            issue2(2'(a), 2'(b), 1'(c), 1'(s));
            wait2();
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
REQ-006 op_a  input  WIDTH  first operand; sampled with start.
REQ-007 op_b  input  WIDTH  second operand; sampled with start.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1; sampled with start.
REQ-009 busy  output  1  high while operation in progress (state RUN).
REQ-010 done  output  1  registered single-cycle completion pulse.
REQ-011 result  output  WIDTH  sum/difference; held stable from done until next accepted start.
REQ-012 cout  output  1  final carry out (for subtract: 1 = no borrow).
REQ-013 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 Block SHALL compute result bit-serially, LSB first, one bit per clock, through exactly one instance of one_bit_full_adder (ports a, b, cin, sum, cout); no parallel adder permitted.
REQ-015 FSM SHALL have states IDLE, RUN, DONE; encoding free.
REQ-016 IDLE -> RUN on edge where start=1; at that edge latch op_a, op_b XOR {WIDTH{sub}}, carry register <= (sub ? 1 : cin), bit counter <= 0.
REQ-017 RUN, each edge: result[cnt] <= adder sum, carry register <= adder cout, cnt <= cnt+1; adder inputs are latched op_a[cnt], latched op_b[cnt], carry register.
REQ-018 RUN -> DONE on the edge processing cnt = WIDTH-1; at that edge cout <= adder cout, overflow <= carry register XOR adder cout.
REQ-019 DONE -> IDLE unconditionally on next edge; done = 1 exactly while in DONE.
REQ-020 Latency: start sampled at edge E0; done high in cycle after edge E0+WIDTH; IDLE again at E0+WIDTH+1; busy high between E0 and E0+WIDTH.
REQ-021 start in RUN or DONE SHALL be ignored (not queued); changes on op_a/op_b/sub/cin after acceptance SHALL not affect the operation.
REQ-022 start held high continuously SHALL start a new operation every WIDTH+2 cycles (accepted in each IDLE).
REQ-023 Arithmetic modulo 2^WIDTH; wrap-around reported only via cout/overflow.
REQ-024 result, cout, overflow SHALL update only during RUN/DONE transition edges; retain values in IDLE.
REQ-025 Bit counter width ceil(log2(WIDTH)); SHALL not wrap within an operation.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, cout=0, overflow=0, counter=0, carry register=0.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; first start after reset_n rises SHALL behave as from power-up.

Verification
REQ-028 WIDTH=8, op_a=0x05, op_b=0x03, cin=0, sub=0, start 1 cycle -> busy 8 cycles, done 1 cycle, result=0x08, cout=0, overflow=0.
REQ-029 op_a=0xFF, op_b=0x01, cin=0, sub=0 -> result=0x00, cout=1, overflow=0; op_a=0x7F, op_b=0x01 -> result=0x80, overflow=1.
REQ-030 sub=1, op_a=0x10, op_b=0x01, cin=1 -> result=0x0F, cout=1; op_a=0x00, op_b=0x01 -> result=0xFF, cout=0.
REQ-031 start pulsed again 3 cycles after acceptance with different operands -> ignored; first operation result unchanged, single done.
REQ-032 reset_n low 4 cycles into RUN -> all outputs 0 immediately, no done; next start 0x01+0x01 -> result=0x02.
REQ-033 Exhaustive WIDTH=2: all op_a, op_b, cin, sub combinations -> result/cout/overflow match reference model, each done exactly WIDTH+1 edges after start.
